// File: rtl/sram_like_if.sv
// Sram-like request/response bundle: one master issues req + fields,
// one slave answers with addr_ok (accept) and data_ok/rdata (complete).
interface sram_like_if #(
    parameter int AW = 32,
    parameter int DW = 32
) ();
    logic          req;
    logic          wr;
    logic [1:0]    size;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          addr_ok;
    logic          data_ok;
    logic [DW-1:0] rdata;

    modport master (
        output req, wr, size, addr, wdata,
        input  addr_ok, data_ok, rdata
    );

    modport slave (
        input  req, wr, size, addr, wdata,
        output addr_ok, data_ok, rdata
    );
endinterface

// File: rtl/sram_like_arbiter.sv
// Shares one sram-like slave port between the inst-fetch and data masters.
// One transaction in flight; data has priority, bounded by a starvation counter.
module sram_like_arbiter #(
    parameter int AW           = 32,
    parameter int DW           = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic       clk,
    input  logic       resetn,
    sram_like_if.slave  inst,
    sram_like_if.slave  data,
    sram_like_if.master s
);
    localparam int CW = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [1:0] {IDLE, ADDR, RESP} state_t;
    typedef enum logic {OWN_INST, OWN_DATA} owner_t;

    state_t        state;
    state_t        next_state;
    owner_t        owner;
    logic [CW-1:0] starve_cnt;
    logic          grant_data;
    logic          owner_req;
    logic [AW-1:0] owner_addr;
    logic [DW-1:0] owner_wdata;

    // Inst is forced only once data has won STARVE_LIMIT times in a row over a waiting inst.
    assign grant_data = data.req && !(inst.req && (starve_cnt == CW'(STARVE_LIMIT)));
    assign owner_req  = (owner == OWN_DATA) ? data.req : inst.req;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= IDLE;
            owner      <= OWN_DATA;
            starve_cnt <= '0;
        end else begin
            state <= next_state;
            if (state == IDLE && (inst.req || data.req)) begin
                owner <= grant_data ? OWN_DATA : OWN_INST;
                if (grant_data && inst.req) begin
                    if (starve_cnt != CW'(STARVE_LIMIT))
                        starve_cnt <= starve_cnt + 1'b1;
                end else begin
                    starve_cnt <= '0;
                end
            end
        end
    end

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE: if (inst.req || data.req) next_state = ADDR;
            ADDR: begin
                if (s.addr_ok)       next_state = RESP;
                else if (!owner_req) next_state = IDLE;
            end
            RESP: if (s.data_ok) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Slave fields are only driven while a request is being presented.
    always_comb begin
        s.req        = 1'b0;
        s.wr         = 1'b0;
        s.size       = 2'b00;
        owner_addr   = '0;
        owner_wdata  = '0;
        inst.addr_ok = 1'b0;
        inst.data_ok = 1'b0;
        data.addr_ok = 1'b0;
        data.data_ok = 1'b0;
        if (state == ADDR) begin
            s.req = 1'b1;
            if (owner == OWN_DATA) begin
                s.wr         = data.wr;
                s.size       = data.size;
                owner_addr   = data.addr;
                owner_wdata  = data.wdata;
                data.addr_ok = s.addr_ok;
            end else begin
                s.wr         = inst.wr;
                s.size       = inst.size;
                owner_addr   = inst.addr;
                owner_wdata  = inst.wdata;
                inst.addr_ok = s.addr_ok;
            end
        end else if (state == RESP) begin
            if (owner == OWN_DATA) data.data_ok = s.data_ok;
            else                   inst.data_ok = s.data_ok;
        end
    end

    assign s.addr     = owner_addr;
    assign s.wdata    = owner_wdata;
    assign inst.rdata = s.rdata;
    assign data.rdata = s.rdata;
endmodule

// File: tb/tb_sram_like_arbiter.sv
// Directed and randomized bench for sram_like_arbiter; expectations come from a
// transaction-level model of pending requests and the data-vs-inst starvation rule.
module tb_sram_like_arbiter;
    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int LIMIT = 4;

    typedef struct packed {
        logic        wr;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
    } req_t;

    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    sram_like_if #(.AW(AW), .DW(DW)) inst_bus ();
    sram_like_if #(.AW(AW), .DW(DW)) data_bus ();
    sram_like_if #(.AW(AW), .DW(DW)) s_bus ();

    sram_like_arbiter #(.AW(AW), .DW(DW), .STARVE_LIMIT(LIMIT)) dut (
        .clk    (clk),
        .resetn (resetn),
        .inst   (inst_bus),
        .data   (data_bus),
        .s      (s_bus)
    );

    int    errors = 0;
    int    checks = 0;
    req_t  ireq, dreq;
    bit    ipend, dpend;
    int    streak;
    string obs_grants;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b, expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_oks(input string tag, input bit sreq, input bit iaok, input bit idok,
                           input bit daok, input bit ddok);
        chk1({tag, ".s_req"},        s_bus.req,        sreq);
        chk1({tag, ".inst_addr_ok"}, inst_bus.addr_ok, iaok);
        chk1({tag, ".inst_data_ok"}, inst_bus.data_ok, idok);
        chk1({tag, ".data_addr_ok"}, data_bus.addr_ok, daok);
        chk1({tag, ".data_data_ok"}, data_bus.data_ok, ddok);
    endtask

    task automatic chk_fields(input string tag, input req_t w);
        chk1 ({tag, ".s_wr"},    s_bus.wr,         w.wr);
        chk32({tag, ".s_size"},  32'(s_bus.size),  32'(w.size));
        chk32({tag, ".s_addr"},  s_bus.addr,       w.addr);
        chk32({tag, ".s_wdata"}, s_bus.wdata,      w.wdata);
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic new_req(output req_t r);
        r.wr    = 1'($urandom_range(0, 1));
        r.size  = 2'($urandom_range(0, 2));
        r.addr  = $urandom;
        r.wdata = $urandom;
    endtask

    task automatic drive_masters();
        inst_bus.req   = ipend;
        inst_bus.wr    = ireq.wr;
        inst_bus.size  = ireq.size;
        inst_bus.addr  = ireq.addr;
        inst_bus.wdata = ireq.wdata;
        data_bus.req   = dpend;
        data_bus.wr    = dreq.wr;
        data_bus.size  = dreq.size;
        data_bus.addr  = dreq.addr;
        data_bus.wdata = dreq.wdata;
    endtask

    task automatic apply_reset();
        resetn = 1'b0;
        for (int i = 0; i < 3; i++) begin
            inst_bus.req    = 1'($urandom_range(0, 1));
            data_bus.req    = 1'($urandom_range(0, 1));
            data_bus.wr     = 1'($urandom_range(0, 1));
            data_bus.addr   = $urandom;
            s_bus.addr_ok   = 1'($urandom_range(0, 1));
            s_bus.data_ok   = 1'($urandom_range(0, 1));
            s_bus.rdata     = $urandom;
            @(negedge clk);
            chk_oks("reset", 0, 0, 0, 0, 0);
            chk1 ("reset.s_wr",    s_bus.wr,    1'b0);
            chk32("reset.s_addr",  s_bus.addr,  32'h0);
            chk32("reset.s_wdata", s_bus.wdata, 32'h0);
            chk32("reset.s_size",  32'(s_bus.size), 32'h0);
        end
        ipend = 0; dpend = 0; streak = 0;
        ireq = '0; dreq = '0;
        drive_masters();
        s_bus.addr_ok = 1'b0;
        s_bus.data_ok = 1'b0;
        next_cyc();
        resetn = 1'b1;
    endtask

    // One arbitration round starting in an idle cycle; at least one master must be pending.
    task automatic run_txn(input bit abandon, input int aw, input int dw, input logic [31:0] rd);
        bit    wd;
        req_t  w;
        string g;
        wd = dpend && !(ipend && streak == LIMIT);
        w  = wd ? dreq : ireq;
        if (wd && ipend) streak = (streak < LIMIT) ? streak + 1 : LIMIT;
        else             streak = 0;

        drive_masters();
        s_bus.addr_ok = 1'($urandom_range(0, 1));
        s_bus.data_ok = 1'($urandom_range(0, 1));
        @(negedge clk);
        chk_oks("arb", 0, 0, 0, 0, 0);
        next_cyc();
        s_bus.addr_ok = 1'b0;
        s_bus.data_ok = 1'b0;
        for (int i = 0; i < aw; i++) begin
            @(negedge clk);
            chk_oks("addr_wait", 1, 0, 0, 0, 0);
            chk_fields("addr_wait", w);
            next_cyc();
        end
        if (abandon) begin
            if (wd) dpend = 0; else ipend = 0;
            drive_masters();
            @(negedge clk);
            chk_oks("abandon", 1, 0, 0, 0, 0);
            next_cyc();
            return;
        end
        s_bus.addr_ok = 1'b1;
        @(negedge clk);
        chk_oks("addr_ok", 1, !wd, 0, wd, 0);
        chk_fields("addr_ok", w);
        g = data_bus.addr_ok ? "D" : (inst_bus.addr_ok ? "I" : "-");
        obs_grants = {obs_grants, g};
        next_cyc();
        s_bus.addr_ok = 1'b0;
        if (wd) dpend = 0; else ipend = 0;
        drive_masters();
        for (int i = 0; i < dw; i++) begin
            s_bus.addr_ok = 1'($urandom_range(0, 1));
            @(negedge clk);
            chk_oks("resp_wait", 0, 0, 0, 0, 0);
            next_cyc();
        end
        s_bus.addr_ok = 1'b0;
        s_bus.data_ok = 1'b1;
        s_bus.rdata   = rd;
        @(negedge clk);
        chk_oks("data_ok", 0, 0, !wd, 0, wd);
        chk32("inst_rdata", inst_bus.rdata, rd);
        chk32("data_rdata", data_bus.rdata, rd);
        next_cyc();
        s_bus.data_ok = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn = 1'b0;
        ipend = 0; dpend = 0; streak = 0; ireq = '0; dreq = '0;
        drive_masters();
        s_bus.addr_ok = 1'b0; s_bus.data_ok = 1'b0; s_bus.rdata = '0;
        apply_reset();

        // Single instruction read
        ipend = 1;
        ireq.wr = 1'b0; ireq.size = 2'd2; ireq.addr = 32'hBFC00000; ireq.wdata = 32'h0;
        run_txn(0, 0, 1, 32'h3C1D0000);
        @(negedge clk);
        chk_oks("after_inst_read", 0, 0, 0, 0, 0);
        next_cyc();

        // Collision: data write wins, inst follows after the bubble
        ipend = 1; new_req(ireq); ireq.wr = 1'b0;
        dpend = 1;
        dreq.wr = 1'b1; dreq.size = 2'd2; dreq.addr = 32'h80001000; dreq.wdata = 32'hDEADBEEF;
        run_txn(0, 0, 0, $urandom);
        run_txn(0, 1, 0, $urandom);

        // Abandon: data owner drops in ADDR, pending inst gets the next grant
        ipend = 1; new_req(ireq);
        dpend = 1; new_req(dreq);
        run_txn(1, 1, 0, 32'h0);
        run_txn(0, 0, 1, $urandom);

        // Starvation: data re-requests every round while inst waits
        apply_reset();
        ipend = 1; new_req(ireq);
        obs_grants = "";
        for (int r = 0; r < 6; r++) begin
            dpend = 1; new_req(dreq);
            run_txn(0, $urandom_range(0, 1), $urandom_range(0, 1), $urandom);
        end
        checks++;
        assert (obs_grants == "DDDDID") else begin
            errors++;
            $error("FAIL starve_order: observed %s, expected DDDDID", obs_grants);
        end

        // Reset in RESP, then a late s_data_ok
        dpend = 1; new_req(dreq);
        drive_masters();
        @(negedge clk);
        next_cyc();
        s_bus.addr_ok = 1'b1;
        next_cyc();
        s_bus.addr_ok = 1'b0;
        dpend = 0;
        drive_masters();
        @(negedge clk);
        chk_oks("midop_resp", 0, 0, 0, 0, 0);
        s_bus.data_ok = 1'b1;
        s_bus.rdata   = $urandom;
        resetn = 1'b0;
        #1;
        chk_oks("midop_reset", 0, 0, 0, 0, 0);
        next_cyc();
        resetn = 1'b1;
        @(negedge clk);
        chk_oks("late_data_ok", 0, 0, 0, 0, 0);
        next_cyc();
        s_bus.data_ok = 1'b0;
        streak = 0;

        // Randomized rounds
        for (int r = 0; r < 40; r++) begin
            if (!ipend && $urandom_range(0, 1) == 1) begin ipend = 1; new_req(ireq); end
            if (!dpend && $urandom_range(0, 2) != 0) begin dpend = 1; new_req(dreq); end
            if (!ipend && !dpend) begin dpend = 1; new_req(dreq); end
            run_txn($urandom_range(0, 5) == 0, $urandom_range(0, 2), $urandom_range(0, 2), $urandom);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
